gate_selftest_checker: RTL and testbench
========================================

Name: gate_selftest_checker

Overview:
Built-in self-test sequencer for the basic logic-gate unit (AND/OR/NOT/XOR). It drives every input combination onto the unit's a/b inputs and waits a programmable settle time. It then samples the unit's four outputs and compares them against an internal golden model. It accumulates an error count and first-failure information, and reports a single pass/fail verdict.

Parameters:
DATA_W, 1, width of each gate operand a and b; gates are bitwise.
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range >= 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a test run; sampled only in IDLE
a_out  out  DATA_W  operand a to gate unit
b_out  out  DATA_W  operand b to gate unit
res_in  in  4*DATA_W  gate results, packed {xor, not, or, and}, each DATA_W wide
busy  out  1  high from run start until DONE is left
done  out  1  one-cycle pulse at end of run
pass  out  1  verdict of last completed run; valid when done pulses, held until next start
err_count  out  2*DATA_W+1  number of failing vectors in current/last run
first_fail_valid  out  1  at least one failure captured in this run
first_fail_vec  out  2*DATA_W  vector index {a,b} of first failure
first_fail_mask  out  4  per-gate mismatch of first failure, bit order {xor,not,or,and}

Behaviour:
- Reset (async, rst_n=0): state IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, first_fail_mask=0.
- Vector index vec is 2*DATA_W bits. a_out=vec[2W-1:W], b_out=vec[W-1:0]. N = 2^(2*DATA_W) vectors, visited in order 0..N-1.
- Golden model: exp = {a_out^b_out, ~a_out, a_out|b_out, a_out&b_out}. mask bit g = OR-reduce of (res_in field g XOR exp field g).
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE: on start=1 at an edge: vec=0, a_out/b_out=0, clear err_count, first_fail_* and pass, busy=1, settle counter=SETTLE_CYCLES, go to WAIT.
- WAIT: stays exactly SETTLE_CYCLES cycles, then goes to CHECK. a_out/b_out stay stable.
- CHECK: one cycle; res_in is sampled at the edge leaving CHECK.
  - If mask != 0: increment err_count. If first_fail_valid=0, also capture vec and mask and set first_fail_valid.
  - If vec = N-1: go to DONE.
  - Otherwise vec+1, update a_out/b_out at the same edge, reload counter, go to WAIT.
- DONE: done=1 for exactly one cycle. pass=(err_count==0), registered on entry to DONE, so it is valid in the done cycle. busy=0 from the edge leaving DONE. Return to IDLE. a_out/b_out hold the last vector.
- Timing: start sampled at edge k gives done high in the cycle after edge k+N*(SETTLE_CYCLES+1). For DATA_W=1, SETTLE_CYCLES=1 that is edge k+8.
- start while busy, including in DONE: ignored. No restart and no abort.
- err_count cannot overflow: its maximum is N, which fits in 2*DATA_W+1 bits.
- Reset mid-run: all state returns to reset values immediately, with no done pulse. The next start begins a fresh run.
- res_in is treated as a registered-domain input; no synchroniser.

Decomposition:
- Package gate_test_pkg: FSM state enum; field index constants GATE_AND=0, GATE_OR=1, GATE_NOT=2, GATE_XOR=3; function to pack expected results.
- One sub-module, gate_golden_model: purely combinational; a, b in; 4*DATA_W expected vector out. It is instantiated once, fed from a_out/b_out.
- Counters and the FSM stay in the top module.

Test Plan:
- Correct gate model, DATA_W=1, SETTLE_CYCLES=1, start at edge k -> a/b step 00,01,10,11, each held 2 cycles; done pulses after edge k+8; pass=1, err_count=0, first_fail_valid=0.
- AND output stuck at 0 -> only vector 3 fails; err_count=1, first_fail_vec=3, first_fail_mask=0001, pass=0.
- XOR output inverted -> all 4 vectors fail; err_count=4, first_fail_vec=0, first_fail_mask=1000, pass=0.
- SETTLE_CYCLES=3, model outputs updated with 2-cycle delay -> pass=1; done after edge k+16; a_out/b_out stable 4 cycles per vector.
- start re-pulsed while busy -> no effect on sequence or timing; rst_n pulsed low mid-run -> all outputs at reset values, no done; a new start gives the full correct run.
- DATA_W=2, correct model -> 16 vectors, done after edge k+32, pass=1, err_count=0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM states, gate field indices and golden packing for the gate self-test
package gate_test_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;
    localparam int GATE_AND = 0;
    localparam int GATE_OR  = 1;
    localparam int GATE_NOT = 2;
    localparam int GATE_XOR = 3;
    function automatic logic [3:0] pack_expected(input logic a, input logic b);
        logic [3:0] r;
        r[GATE_AND] = a & b;
        r[GATE_OR]  = a | b;
        r[GATE_NOT] = ~a;
        r[GATE_XOR] = a ^ b;
        return r;
    endfunction
endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model: combinational reference results packed {xor, not, or, and}, each DATA_W wide
module gate_golden_model import gate_test_pkg::*; #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [4*DATA_W-1:0] o_exp
);
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        logic [3:0] w_bit;
        assign w_bit = pack_expected(i_a[i], i_b[i]);
        for (genvar g = 0; g < 4; g++) begin : g_gate
            assign o_exp[g*DATA_W+i] = w_bit[g];
        end
    end
endmodule

// File: rtl/gate_selftest_checker.sv
// gate_selftest_checker: sweeps all a/b vectors into a gate unit and checks its results against a golden model
module gate_selftest_checker import gate_test_pkg::*; #(
    parameter int DATA_W        = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_W-1:0]     a_out,
    output logic [DATA_W-1:0]     b_out,
    input  logic [4*DATA_W-1:0]   res_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*DATA_W:0]     err_count,
    output logic                  first_fail_valid,
    output logic [2*DATA_W-1:0]   first_fail_vec,
    output logic [3:0]            first_fail_mask
);
    localparam int VEC_W = 2 * DATA_W;
    localparam int ERR_W = VEC_W + 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_cnt;
    logic [ERR_W-1:0]   r_err;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_ffv;
    logic [VEC_W-1:0]   r_ffvec;
    logic [3:0]         r_ffmask;
    logic [4*DATA_W-1:0] w_exp;
    logic [3:0]         w_mask;
    logic [ERR_W-1:0]   w_err_next;

    gate_golden_model #(.DATA_W(DATA_W)) u_golden (
        .i_a   (a_out),
        .i_b   (b_out),
        .o_exp (w_exp)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mask
        assign w_mask[g] = |(res_in[g*DATA_W +: DATA_W] ^ w_exp[g*DATA_W +: DATA_W]);
    end

    assign w_err_next       = r_err + ERR_W'(|w_mask);
    assign a_out            = r_vec[VEC_W-1:DATA_W];
    assign b_out            = r_vec[DATA_W-1:0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;
    assign first_fail_mask  = r_ffmask;

    // Sequencer: settle each vector, compare in CHECK, accumulate errors, pulse done at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_ffv    <= 1'b0;
            r_ffvec  <= '0;
            r_ffmask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_vec    <= '0;
                    r_err    <= '0;
                    r_ffv    <= 1'b0;
                    r_ffvec  <= '0;
                    r_ffmask <= '0;
                    r_pass   <= 1'b0;
                    r_busy   <= 1'b1;
                    r_cnt    <= CNT_W'(SETTLE_CYCLES);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) r_state <= ST_CHECK;
                    else r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_CHECK: begin
                    if (|w_mask) begin
                        r_err <= w_err_next;
                        if (!r_ffv) begin
                            r_ffv    <= 1'b1;
                            r_ffvec  <= r_vec;
                            r_ffmask <= w_mask;
                        end
                    end
                    if (r_vec == '1) begin
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_cnt   <= CNT_W'(SETTLE_CYCLES);
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_selftest_checker.sv
// tb_gate_selftest_checker: scoreboard bench for three checker configurations driving stand-in gate units
module tb_gate_selftest_checker;
    typedef struct {
        int err;
        int ffv;
        int ffvec;
        int ffmask;
        int pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   sel = 1;
    int   fault = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    logic       st1 = 1'b0, a1, b1, busy1, done1, pass1, ffv1;
    logic [3:0] res1, ffm1;
    logic [2:0] err1;
    logic [1:0] ffvec1;

    logic       st3 = 1'b0, a3, b3, busy3, done3, pass3, ffv3, a3_d1, b3_d1, a3_d2, b3_d2;
    logic [3:0] res3, ffm3;
    logic [2:0] err3;
    logic [1:0] ffvec3;

    logic       st2 = 1'b0, busy2, done2, pass2, ffv2;
    logic [1:0] a2, b2;
    logic [7:0] res2;
    logic [3:0] ffm2, ffvec2;
    logic [4:0] err2;

    assign res1 = {a1 ^ b1 ^ (fault == 2), ~a1, a1 | b1, (fault == 1) ? 1'b0 : (a1 & b1)};
    assign res3 = {a3_d2 ^ b3_d2, ~a3_d2, a3_d2 | b3_d2, a3_d2 & b3_d2};
    assign res2 = {a2 ^ b2, ~a2, a2 | b2, a2 & b2};

    // Gate unit with a two-cycle output delay for the long-settle checker
    always_ff @(posedge clk) begin
        a3_d1 <= a3;
        b3_d1 <= b3;
        a3_d2 <= a3_d1;
        b3_d2 <= b3_d1;
    end

    gate_selftest_checker #(.DATA_W(1), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a_out(a1), .b_out(b1), .res_in(res1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_mask(ffm1));

    gate_selftest_checker #(.DATA_W(1), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .a_out(a3), .b_out(b3), .res_in(res3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .first_fail_mask(ffm3));

    gate_selftest_checker #(.DATA_W(2), .SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a_out(a2), .b_out(b2), .res_in(res2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_mask(ffm2));

    logic [31:0] o_a, o_b, o_err, o_ffvec, o_ffm;
    logic        o_busy, o_done, o_pass, o_ffv;

    // Observe whichever checker the current run targets
    always_comb begin
        o_a = 32'(a1); o_b = 32'(b1); o_err = 32'(err1); o_ffvec = 32'(ffvec1); o_ffm = 32'(ffm1);
        o_busy = busy1; o_done = done1; o_pass = pass1; o_ffv = ffv1;
        if (sel == 3) begin
            o_a = 32'(a3); o_b = 32'(b3); o_err = 32'(err3); o_ffvec = 32'(ffvec3); o_ffm = 32'(ffm3);
            o_busy = busy3; o_done = done3; o_pass = pass3; o_ffv = ffv3;
        end else if (sel == 2) begin
            o_a = 32'(a2); o_b = 32'(b2); o_err = 32'(err2); o_ffvec = 32'(ffvec2); o_ffm = 32'(ffm2);
            o_busy = busy2; o_done = done2; o_pass = pass2; o_ffv = ffv2;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) st1 = v;
        else if (sel == 3) st3 = v;
        else st2 = v;
    endtask

    task automatic check_reset_values();
        check("rst_a", o_a, 0);
        check("rst_b", o_b, 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_pass", 32'(o_pass), 0);
        check("rst_err", o_err, 0);
        check("rst_ffv", 32'(o_ffv), 0);
        check("rst_ffvec", o_ffvec, 0);
        check("rst_ffmask", o_ffm, 0);
    endtask

    task automatic run(input int s_sel, input int w, input int s, input exp_t e, input bit repulse);
        int n, span, lat, vec;
        bit seen;
        exp_t got;
        sel = s_sel;
        n = 1 << (2 * w);
        span = n * (s + 1);
        sb.push_back(e);
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        check("busy_on", 32'(o_busy), 1);
        check("err_clear", o_err, 0);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat <= span + 4) begin
            if (o_done) seen = 1'b1;
            else begin
                vec = lat / (s + 1);
                check("vec_a", o_a, 32'(vec >> w));
                check("vec_b", o_b, 32'(vec & ((1 << w) - 1)));
                check("busy_run", 32'(o_busy), 1);
                set_start(repulse && (lat == 2 || lat == span - 1));
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        got = sb.pop_front();
        check("done_latency", 32'(lat), 32'(span));
        check("err_count", o_err, 32'(got.err));
        check("ff_valid", 32'(o_ffv), 32'(got.ffv));
        check("ff_vec", o_ffvec, 32'(got.ffvec));
        check("ff_mask", o_ffm, 32'(got.ffmask));
        check("pass", 32'(o_pass), 32'(got.pass));
        check("busy_done", 32'(o_busy), 1);
        check("hold_a", o_a, 32'((n - 1) >> w));
        check("hold_b", o_b, 32'((n - 1) & ((1 << w) - 1)));
        set_start(repulse);
        @(posedge clk);
        #1;
        set_start(1'b0);
        check("done_pulse", 32'(o_done), 0);
        check("busy_off", 32'(o_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_restart", 32'(o_busy), 0);
        check("pass_held", 32'(o_pass), 32'(got.pass));
        check("err_held", o_err, 32'(got.err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        run(1, 1, 1, '{err: 0, ffv: 0, ffvec: 0, ffmask: 0, pass: 1}, 1'b0);
        fault = 1;
        run(1, 1, 1, '{err: 1, ffv: 1, ffvec: 3, ffmask: 1, pass: 0}, 1'b0);
        fault = 2;
        run(1, 1, 1, '{err: 4, ffv: 1, ffvec: 0, ffmask: 8, pass: 0}, 1'b0);
        fault = 0;
        run(1, 1, 1, '{err: 0, ffv: 0, ffvec: 0, ffmask: 0, pass: 1}, 1'b1);
        run(3, 1, 3, '{err: 0, ffv: 0, ffvec: 0, ffmask: 0, pass: 1}, 1'b0);
        sel = 1;
        fault = 2;
        @(negedge clk);
        st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mid_busy", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_no_done", 32'(o_done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        run(1, 1, 1, '{err: 0, ffv: 0, ffvec: 0, ffmask: 0, pass: 1}, 1'b0);
        run(2, 2, 1, '{err: 0, ffv: 0, ffvec: 0, ffmask: 0, pass: 1}, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
